// File: rtl/std_linear_sec_scrubber_pkg.sv
// Shared types and code-shape helpers for the SEC scrubber.
// Column helper defines the parity-check matrix used by the codec pair.
package std_linear_sec_scrubber_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      READ,
      CHECK,
      WRITE,
      NEXT
   } state_t;

   function automatic int sec_n(input int p);
      return (1 << p) - 1 - p;
   endfunction

   function automatic int sec_k(input int p);
      return (1 << p) - 1;
   endfunction

   // Parity-check column of codeword bit i: parity bits sit in the
   // low p positions with unit columns, data bits take the remaining
   // non-power-of-two values in ascending order.
   function automatic int sec_col(input int p, input int i);
      int c;
      int col;
      col = 1 << i;
      c   = p;
      for (int v = 3; v < (1 << p); v++) begin
         if (i >= p && (v & (v - 1)) != 0) begin
            if (c == i) col = v;
            c++;
         end
      end
      return col;
   endfunction

endpackage

// File: rtl/std_linear_sec_decoder.sv
// Systematic SEC decoder: syndrome lookup, flips the matching data bit.
// Any non-zero syndrome is reported as a correction.
module std_linear_sec_decoder
   import std_linear_sec_scrubber_pkg::*;
#(
   parameter int  P = 4,
   localparam int N = sec_n(P),
   localparam int K = sec_k(P)
) (
   input  logic [K-1:0] i_code,
   output logic [N-1:0] o_word,
   output logic         o_corrected
);

   logic [P-1:0] syn;

   // syndrome then single-bit repair of the data field
   always_comb begin
      syn = '0;
      for (int i = 0; i < K; i++) begin
         if (i_code[i]) syn = syn ^ P'(sec_col(P, i));
      end
      o_word = i_code[K-1:P];
      for (int j = 0; j < N; j++) begin
         if (syn == P'(sec_col(P, P + j))) o_word[j] = ~i_code[P + j];
      end
   end

   assign o_corrected = |syn;

endmodule

// File: rtl/std_linear_sec_encoder.sv
// Systematic SEC encoder: codeword = {data, parity}.
// Parity bit b is the XOR of the data bits whose column has bit b set.
module std_linear_sec_encoder
   import std_linear_sec_scrubber_pkg::*;
#(
   parameter int  P = 4,
   localparam int N = sec_n(P),
   localparam int K = sec_k(P)
) (
   input  logic [N-1:0] i_data,
   output logic [K-1:0] o_code
);

   logic [P-1:0] par;

   // accumulate parity from each set data bit's column
   always_comb begin
      par = '0;
      for (int j = 0; j < N; j++) begin
         if (i_data[j]) par = par ^ P'(sec_col(P, P + j));
      end
   end

   assign o_code = {i_data, par};

endmodule

// File: rtl/std_linear_sec_scrubber.sv
// Background scrubber: walks memory, decodes each word and writes
// back re-encoded data whenever the decoder reports a correction.
module std_linear_sec_scrubber
   import std_linear_sec_scrubber_pkg::*;
#(
   parameter int  P  = 4,
   parameter int  AW = 4,
   parameter int  IW = 8,
   parameter int  CW = 16,
   localparam int N  = sec_n(P),
   localparam int K  = sec_k(P)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   input  logic [IW-1:0] i_interval,
   output logic          o_mem_req,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [K-1:0]  o_mem_wdata,
   input  logic          i_mem_ack,
   input  logic [K-1:0]  i_mem_rdata,
   output logic [CW-1:0] o_corrected_count,
   output logic          o_pass_done,
   output logic          o_busy
);

   state_t        state_q;
   state_t        state_d;
   logic [AW-1:0] addr_q;
   logic [IW-1:0] wait_q;
   logic [K-1:0]  cw_q;
   logic [CW-1:0] corr_q;
   logic          done_q;
   logic [N-1:0]  dec_word;
   logic          dec_corr;
   logic [K-1:0]  enc_code;

   std_linear_sec_decoder #(.P(P)) u_dec (
      .i_code      (cw_q),
      .o_word      (dec_word),
      .o_corrected (dec_corr)
   );

   std_linear_sec_encoder #(.P(P)) u_enc (
      .i_data (dec_word),
      .o_code (enc_code)
   );

   // state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_en) state_d = WAIT;
         WAIT:    if (wait_q == '0) state_d = READ;
         READ:    if (i_mem_ack) state_d = CHECK;
         CHECK:   state_d = dec_corr ? WRITE : NEXT;
         WRITE:   if (i_mem_ack) state_d = NEXT;
         NEXT:    state_d = i_en ? WAIT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // address walk, idle timer, codeword capture and correction count
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         addr_q <= '0;
         wait_q <= '0;
         cw_q   <= '0;
         corr_q <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE:  if (i_en) wait_q <= i_interval;
            WAIT:  if (wait_q != '0) wait_q <= wait_q - 1'b1;
            READ:  if (i_mem_ack) cw_q <= i_mem_rdata;
            CHECK: if (dec_corr) cw_q <= enc_code;
            WRITE: begin
               if (i_mem_ack && corr_q != '1) corr_q <= corr_q + 1'b1;
            end
            NEXT: begin
               addr_q <= addr_q + 1'b1;
               done_q <= &addr_q;
               if (i_en) wait_q <= i_interval;
            end
            default: ;
         endcase
      end
   end

   assign o_mem_req         = (state_q == READ) || (state_q == WRITE);
   assign o_mem_we          = (state_q == WRITE);
   assign o_mem_addr        = addr_q;
   assign o_mem_wdata       = (state_q == WRITE) ? cw_q : '0;
   assign o_corrected_count = corr_q;
   assign o_pass_done       = done_q;
   assign o_busy            = (state_q != IDLE);

endmodule
